// File: rtl/poly_pkg.sv
// Shared widths, rounding/saturation constants and the output clamp helper
// for the second-order Horner evaluator.
package poly_pkg;
  localparam int XW         = 17;
  localparam int C0W        = 21;
  localparam int C12W       = 18;
  localparam int FRAC       = 17;
  localparam int ROUND_HALF = 1 << (FRAC - 1);
  localparam int Y_MAX      = (1 << 20) - 1;
  localparam int Y_MIN      = -(1 << 20);

  // Internal datapath widths (x is zero-extended by one bit before multiplying).
  localparam int P1W = C12W + XW + 1;   // coef2 * x
  localparam int S1W = 20;              // inner Horner sum
  localparam int P2W = S1W + XW + 1;    // s1 * x
  localparam int RW  = C0W + 1;         // unclamped result

  typedef struct packed {
    logic signed [C0W-1:0] y;
    logic                  sat;
  } clamp_t;

  function automatic clamp_t clamp_y(input logic signed [RW-1:0] r);
    clamp_t c;
    c.sat = 1'b1;
    if (r > RW'(Y_MAX))      c.y = C0W'(Y_MAX);
    else if (r < RW'(Y_MIN)) c.y = C0W'(Y_MIN);
    else begin
      c.y   = r[C0W-1:0];
      c.sat = 1'b0;
    end
    return c;
  endfunction
endpackage

// File: rtl/poly_eval_rnd_shift.sv
// Round-half-up right shift by FRAC: floor((din + 2^(FRAC-1)) / 2^FRAC).
// Output carries one extra bit so the rounding carry can never wrap.
module rnd_shift
  import poly_pkg::*;
#(
  parameter int IW = 36
) (
  input  logic signed [IW-1:0]      din,
  output logic signed [IW-FRAC:0]   dout
);
  logic signed [IW:0] sum;

  always_comb begin
    sum  = $signed({din[IW-1], din}) + (IW+1)'(ROUND_HALF);
    dout = (IW-FRAC+1)'(sum >>> FRAC);
  end
endmodule

// File: rtl/poly_eval.sv
// Five-stage pipelined Horner evaluator y = (coef2*x + coef1)*x + coef0 with
// round-half-up scaling after each multiply and saturation on the final add.
module poly_eval
  import poly_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_in,
  input  logic [XW-1:0]          x_in,
  input  logic signed [C0W-1:0]  coef0,
  input  logic signed [C12W-1:0] coef1,
  input  logic signed [C12W-1:0] coef2,
  output logic                   out_valid,
  output logic signed [C0W-1:0]  y_out,
  output logic                   sat
);
  logic                   v1, v2, v3, v4;
  logic [XW-1:0]          x_d1, x_d2, x_d3;
  logic signed [P1W-1:0]  p1;
  logic signed [C12W-1:0] c1_d2;
  logic signed [C0W-1:0]  c0_d2, c0_d3, c0_d4;
  logic signed [S1W-1:0]  s1;
  logic signed [P2W-1:0]  p2;
  logic signed [S1W-1:0]  r1;
  logic signed [RW-1:0]   r2;
  logic signed [RW-1:0]   r;
  clamp_t                 clamped;

  rnd_shift #(.IW(P1W)) u_rnd1 (.din(p1), .dout(r1));
  rnd_shift #(.IW(P2W)) u_rnd2 (.din(p2), .dout(r2));

  always_comb begin
    r       = r2 + RW'(c0_d4);
    clamped = clamp_y(r);
  end

  // NOTE: every register, data included, is cleared on reset so a reset
  // mid-stream leaves no stale sample visible on y_out; state is updated
  // with non-blocking assignments so all stages advance on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0; v4 <= 1'b0;
      out_valid <= 1'b0;
      x_d1 <= '0; x_d2 <= '0; x_d3 <= '0;
      p1 <= '0; c1_d2 <= '0; c0_d2 <= '0; c0_d3 <= '0; c0_d4 <= '0;
      s1 <= '0; p2 <= '0;
      y_out <= '0;
      sat   <= 1'b0;
    end else begin
      v1        <= en_in;
      v2        <= v1;
      v3        <= v2;
      v4        <= v3;
      out_valid <= v4;

      if (en_in) x_d1 <= x_in;
      // Coefficients arrive one cycle after en_in, aligned with v1.
      if (v1) begin
        p1    <= coef2 * $signed({1'b0, x_d1});
        c1_d2 <= coef1;
        c0_d2 <= coef0;
        x_d2  <= x_d1;
      end
      if (v2) begin
        s1    <= r1 + S1W'(c1_d2);
        c0_d3 <= c0_d2;
        x_d3  <= x_d2;
      end
      if (v3) begin
        p2    <= s1 * $signed({1'b0, x_d3});
        c0_d4 <= c0_d3;
      end
      if (v4) begin
        y_out <= clamped.y;
        sat   <= clamped.sat;
      end
    end
  end
endmodule

// File: tb/tb_poly_eval.sv
// Self-checking bench for poly_eval: directed vector table, random streaming
// against an arithmetic reference model, gap pattern and mid-stream reset.
module tb_poly_eval;
  logic               clk = 1'b0;
  logic               rst;
  logic               en_in;
  logic [16:0]        x_in;
  logic signed [20:0] coef0;
  logic signed [17:0] coef1;
  logic signed [17:0] coef2;
  logic               out_valid;
  logic signed [20:0] y_out;
  logic               sat;

  poly_eval dut (
    .clk(clk), .rst(rst), .en_in(en_in), .x_in(x_in),
    .coef0(coef0), .coef1(coef1), .coef2(coef2),
    .out_valid(out_valid), .y_out(y_out), .sat(sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc = cyc + 1;

  // Expected-output schedule indexed by the cycle it must be visible in.
  localparam int DEPTH = 2048;
  bit     exp_v  [DEPTH];
  longint exp_y  [DEPTH];
  bit     exp_s  [DEPTH];
  bit     rst_at [DEPTH];
  longint hold_y = 0;
  bit     hold_s = 1'b0;

  // Coefficients owed to the DUT one cycle after their en_in.
  longint p_c0 = 0, p_c1 = 0, p_c2 = 0;

  typedef struct {
    logic [16:0] x;
    longint      c0, c1, c2;
    longint      y;
    bit          s;
  } vec_t;
  vec_t tbl [7];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic longint rnd(input longint v);
    longint t, q;
    t = v + 65536;
    q = t / 131072;
    if (t < 0 && q * 131072 != t) q = q - 1;
    return q;
  endfunction

  function automatic void ref_model(input longint x, c0, c1, c2,
                                    output longint y, output bit s);
    longint s1, r;
    s1 = rnd(c2 * x) + c1;
    r  = rnd(s1 * x) + c0;
    s  = 1'b1;
    if (r > 1048575)       y = 1048575;
    else if (r < -1048576) y = -1048576;
    else begin y = r; s = 1'b0; end
  endfunction

  function automatic longint rs(input int w);
    longint v;
    v = longint'($urandom) & ((64'sd1 <<< w) - 1);
    if (v[w-1]) v = v - (64'sd1 <<< w);
    return v;
  endfunction

  // One clock of stimulus; use_exp selects a table expectation over the model.
  task automatic tick(input bit r, input bit e, input logic [16:0] x,
                      input longint c0, c1, c2,
                      input bit use_exp, input longint ey, input bit es);
    longint y;
    bit     s;
    @(negedge clk);
    rst   = r;
    en_in = e;
    x_in  = x;
    coef0 = p_c0[20:0];
    coef1 = p_c1[17:0];
    coef2 = p_c2[17:0];
    p_c0 = 0; p_c1 = 0; p_c2 = 0;
    if (r) begin
      for (int d = cyc + 1; d <= cyc + 5; d++) exp_v[d] = 1'b0;
      rst_at[cyc + 1] = 1'b1;
    end else if (e) begin
      if (use_exp) begin y = ey; s = es; end
      else ref_model(longint'(x), c0, c1, c2, y, s);
      exp_v[cyc + 5] = 1'b1;
      exp_y[cyc + 5] = y;
      exp_s[cyc + 5] = s;
      p_c0 = c0; p_c1 = c1; p_c2 = c2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, '0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rand_sample(input bit e);
    tick(0, e, 17'($urandom), rs(21), rs(18), rs(18), 0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (rst_at[cyc]) begin
      hold_y = 0;
      hold_s = 1'b0;
    end else if (exp_v[cyc]) begin
      hold_y = exp_y[cyc];
      hold_s = exp_s[cyc];
    end
    check("out_valid", out_valid, exp_v[cyc]);
    check("y_out", $signed(y_out), hold_y);
    check("sat", sat, hold_s);
  end

  initial begin
    rst = 1'b1; en_in = 1'b0; x_in = '0;
    coef0 = '0; coef1 = '0; coef2 = '0;
    rst_at[1] = 1'b1;

    tbl[0] = '{x: 17'd12345,  c0: 1000,     c1: 0,       c2: 0,     y: 1000,     s: 1'b0};
    tbl[1] = '{x: 17'd65536,  c0: 7,        c1: 1000,    c2: 0,     y: 507,      s: 1'b0};
    tbl[2] = '{x: 17'd65536,  c0: 7,        c1: -1000,   c2: 0,     y: -493,     s: 1'b0};
    tbl[3] = '{x: 17'd65536,  c0: 0,        c1: 0,       c2: 65536, y: 16384,    s: 1'b0};
    tbl[4] = '{x: 17'd131071, c0: 1048575,  c1: 131071,  c2: 0,     y: 1048575,  s: 1'b1};
    tbl[5] = '{x: 17'd131071, c0: -1048576, c1: -131072, c2: 0,     y: -1048576, s: 1'b1};
    tbl[6] = '{x: 17'd0,      c0: -5,       c1: 131071,  c2: -7,    y: -5,       s: 1'b0};

    // Reset held for a few cycles; en_in during reset must be ignored.
    tick(1, 1, 17'd100, 500, 0, 0, 0, 0, 0);
    tick(1, 0, '0, 0, 0, 0, 0, 0, 0);

    // Isolated directed vectors: any latency other than 5 shows up as a miss.
    foreach (tbl[i]) begin
      tick(0, 1, tbl[i].x, tbl[i].c0, tbl[i].c1, tbl[i].c2, 1, tbl[i].y, tbl[i].s);
      idle(7);
    end

    // 64 back-to-back random samples.
    for (int i = 0; i < 64; i++) rand_sample(1'b1);
    idle(7);

    // Gap pattern 1,0,1,1,0 must come out unchanged.
    rand_sample(1'b1); rand_sample(1'b0); rand_sample(1'b1);
    rand_sample(1'b1); rand_sample(1'b0);
    idle(7);

    // Four samples in flight, one reset cycle (with en_in high), then a fresh one.
    for (int i = 0; i < 4; i++) rand_sample(1'b1);
    tick(1, 1, 17'($urandom), rs(21), rs(18), rs(18), 0, 0, 0);
    idle(2);
    rand_sample(1'b1);
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
